// File: rtl/iq_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_parameters (package)
// Description : Shared constants, header field positions and the deframer
//               state encoding for the IQ deframer.
// Revision    : 1.0 - initial release
// ============================================================================
package system_parameters;

    localparam int unsigned c_FRAME_PAYLOAD_WORDS_DEFAULT = 8;
    localparam logic [7:0]  c_COMMA_DEFAULT               = 8'hBC;

    // Header word layout: {COMMA, factor, control, reserved zero}
    localparam int unsigned c_HDR_COMMA_MSB  = 31;
    localparam int unsigned c_HDR_COMMA_LSB  = 24;
    localparam int unsigned c_HDR_FACTOR_MSB = 23;
    localparam int unsigned c_HDR_FACTOR_LSB = 20;
    localparam int unsigned c_HDR_CTRL_MSB   = 19;
    localparam int unsigned c_HDR_CTRL_LSB   = 16;
    localparam int unsigned c_HDR_RSVD_MSB   = 15;
    localparam int unsigned c_HDR_RSVD_LSB   = 0;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2
    } deframer_state_t;

    function automatic logic is_header(input logic [31:0] word, input logic [7:0] comma);
        return (word[c_HDR_COMMA_MSB:c_HDR_COMMA_LSB] == comma) &&
               (word[c_HDR_RSVD_MSB:c_HDR_RSVD_LSB] == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_deframer_if.sv
`default_nettype none
// ============================================================================
// Module      : iq_deframer_if
// Description : Input word stream and reconstructed sample stream of the
//               IQ deframer, plus its lock status.
// Revision    : 1.0 - initial release
// ============================================================================
interface iq_deframer_if;

    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [3:0]  outScalingFactor;
    logic [3:0]  outControlData;
    logic        outFirst;
    logic        locked;
    logic [7:0]  syncErrCount;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outData, outScalingFactor, outControlData,
               outFirst, locked, syncErrCount
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outData, outScalingFactor, outControlData,
               outFirst, locked, syncErrCount
    );

endinterface
`default_nettype wire

// File: rtl/iq_deframer_iq_sample_expander.sv
`default_nettype none
// ============================================================================
// Module      : iq_sample_expander
// Description : Expands one signed 8-bit component to 16 bits, scaled by
//               2^factor with saturation to the 16-bit signed range.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_sample_expander (
    input  wire logic [7:0]  i_component,
    input  wire logic [3:0]  i_factor,
    output logic      [15:0] o_sample
);

    // 8-bit value shifted by up to 15 fits in 23 bits; 24 leaves headroom
    logic signed [23:0] w_ext;
    logic signed [23:0] w_shifted;

    assign w_ext     = {{16{i_component[7]}}, i_component};
    assign w_shifted = w_ext <<< i_factor;

    always_comb begin
        o_sample = w_shifted[15:0];
        if (w_shifted > 24'sd32767) begin
            o_sample = 16'h7FFF;
        end else if (w_shifted < -24'sd32768) begin
            o_sample = 16'h8000;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_deframer.sv
`default_nettype none
// ============================================================================
// Module      : iq_deframer
// Description : Aligns to COMMA-headed frames, unpacks two 8-bit IQ samples
//               per payload word and emits scaled 16-bit IQ samples.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_deframer
    import system_parameters::*;
#(
    parameter int unsigned FRAME_PAYLOAD_WORDS = c_FRAME_PAYLOAD_WORDS_DEFAULT,
    parameter logic [7:0]  COMMA               = c_COMMA_DEFAULT
) (
    input wire logic     clk,
    input wire logic     rst,
    iq_deframer_if.slave bus
);

    localparam int unsigned           c_CNT_W     = (FRAME_PAYLOAD_WORDS > 1) ? $clog2(FRAME_PAYLOAD_WORDS) : 1;
    localparam logic [c_CNT_W-1:0]    c_LAST_WORD = c_CNT_W'(FRAME_PAYLOAD_WORDS - 1);

    deframer_state_t    r_state;
    logic [c_CNT_W-1:0] r_word_cnt;
    logic [3:0]         r_factor;
    logic [3:0]         r_control;
    logic               r_locked;
    logic [7:0]         r_sync_err;

    logic [31:0]        r_hold_word;
    logic               r_hold_valid;
    logic               r_hold_phase;
    logic               r_hold_first;

    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic [3:0]         r_out_factor;
    logic [3:0]         r_out_control;
    logic               r_out_first;

    logic               w_out_can;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_accept_payload;
    logic               w_is_header;
    logic               w_src_valid;
    logic               w_out_load;
    logic [31:0]        w_src_word;
    logic               w_src_phase;
    logic               w_src_first;
    logic [7:0]         w_sel_i;
    logic [7:0]         w_sel_q;
    logic [15:0]        w_sample_i;
    logic [15:0]        w_sample_q;

    assign w_out_can = !r_out_valid || bus.outReady;

    // Headers are only taken with the hold empty; payload may refill the
    // hold in the same cycle its last sample moves to the output.
    assign w_in_ready = !rst &&
                        (!r_hold_valid ||
                         ((r_state == ST_PAYLOAD) && r_hold_phase && w_out_can));

    assign w_accept         = bus.inValid && w_in_ready;
    assign w_accept_payload = w_accept && (r_state == ST_PAYLOAD);
    assign w_is_header      = is_header(bus.inData, COMMA);

    always_comb begin
        w_src_word  = r_hold_word;
        w_src_phase = r_hold_phase;
        w_src_first = r_hold_first && !r_hold_phase;
        if (!r_hold_valid) begin
            // Empty hold: sample 0 goes straight from the input to the output
            w_src_word  = bus.inData;
            w_src_phase = 1'b0;
            w_src_first = (r_word_cnt == '0);
        end
    end

    assign w_src_valid = r_hold_valid || w_accept_payload;
    assign w_out_load  = w_src_valid && w_out_can;
    assign w_sel_i     = w_src_phase ? w_src_word[15:8] : w_src_word[31:24];
    assign w_sel_q     = w_src_phase ? w_src_word[7:0]  : w_src_word[23:16];

    iq_sample_expander u_expand_i (
        .i_component (w_sel_i),
        .i_factor    (r_factor),
        .o_sample    (w_sample_i)
    );

    iq_sample_expander u_expand_q (
        .i_component (w_sel_q),
        .i_factor    (r_factor),
        .o_sample    (w_sample_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_word_cnt <= '0;
            r_factor   <= '0;
            r_control  <= '0;
            r_locked   <= 1'b0;
            r_sync_err <= '0;
        end else if (w_accept) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_is_header) begin
                        r_factor   <= bus.inData[c_HDR_FACTOR_MSB:c_HDR_FACTOR_LSB];
                        r_control  <= bus.inData[c_HDR_CTRL_MSB:c_HDR_CTRL_LSB];
                        r_word_cnt <= '0;
                        r_locked   <= 1'b1;
                        r_state    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (r_word_cnt == c_LAST_WORD) begin
                        r_word_cnt <= '0;
                        r_state    <= ST_HEADER;
                    end else begin
                        r_word_cnt <= r_word_cnt + c_CNT_W'(1);
                    end
                end
                ST_HEADER: begin
                    if (w_is_header) begin
                        r_factor  <= bus.inData[c_HDR_FACTOR_MSB:c_HDR_FACTOR_LSB];
                        r_control <= bus.inData[c_HDR_CTRL_MSB:c_HDR_CTRL_LSB];
                        r_state   <= ST_PAYLOAD;
                    end else begin
                        r_locked <= 1'b0;
                        if (r_sync_err != 8'hFF) begin
                            r_sync_err <= r_sync_err + 8'd1;
                        end
                        r_state <= ST_HUNT;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_word   <= '0;
            r_hold_valid  <= 1'b0;
            r_hold_phase  <= 1'b0;
            r_hold_first  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_factor  <= '0;
            r_out_control <= '0;
            r_out_first   <= 1'b0;
        end else begin
            if (r_hold_valid) begin
                if (w_out_load) begin
                    if (!r_hold_phase) begin
                        r_hold_phase <= 1'b1;
                    end else begin
                        r_hold_valid <= w_accept_payload;
                        r_hold_word  <= bus.inData;
                        r_hold_phase <= 1'b0;
                        r_hold_first <= (r_word_cnt == '0);
                    end
                end
            end else if (w_accept_payload) begin
                r_hold_valid <= 1'b1;
                r_hold_word  <= bus.inData;
                r_hold_phase <= w_out_load;
                r_hold_first <= (r_word_cnt == '0);
            end

            if (w_out_load) begin
                r_out_valid   <= 1'b1;
                r_out_data    <= {w_sample_i, w_sample_q};
                r_out_factor  <= r_factor;
                r_out_control <= r_control;
                r_out_first   <= w_src_first;
            end else if (bus.outReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.inReady          = w_in_ready;
    assign bus.outValid         = r_out_valid;
    assign bus.outData          = r_out_data;
    assign bus.outScalingFactor = r_out_factor;
    assign bus.outControlData   = r_out_control;
    assign bus.outFirst         = r_out_first;
    assign bus.locked           = r_locked;
    assign bus.syncErrCount     = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_iq_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_deframer
// Description : Directed self-checking bench for iq_deframer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_iq_deframer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iq_deframer_if bus();

    iq_deframer #(
        .FRAME_PAYLOAD_WORDS (8),
        .COMMA               (8'hBC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {first, factor, control, data} of every consumed sample
    logic [40:0] mon_q[$];

    always @(negedge clk) begin
        if (!rst && bus.outValid && bus.outReady) begin
            mon_q.push_back({bus.outFirst, bus.outScalingFactor, bus.outControlData, bus.outData});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.outReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int waited;
        waited      = 0;
        bus.inValid = 1'b1;
        bus.inData  = w;
        @(negedge clk);
        while (!bus.inReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.inReady) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: inReady=%b required 1 for word %h", bus.inReady, w);
        end
        tick();
        bus.inValid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.inValid  = 1'b1;
        bus.inData   = 32'hBC35_0000;
        bus.outReady = 1'b1;
        tick();
        n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL reset_inReady: got %b required 0", bus.inReady); end
        n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid: got %b required 0", bus.outValid); end
        n_checks++; if (bus.outData !== 32'h0) begin n_fail++; $display("FAIL reset_outData: got %h required 0", bus.outData); end
        n_checks++; if ({bus.outScalingFactor, bus.outControlData, bus.outFirst} !== 9'h0) begin n_fail++; $display("FAIL reset_fields: got %h/%h/%b required 0/0/0", bus.outScalingFactor, bus.outControlData, bus.outFirst); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b required 0", bus.locked); end
        n_checks++; if (bus.syncErrCount !== 8'h0) begin n_fail++; $display("FAIL reset_syncErr: got %0d required 0", bus.syncErrCount); end
        tick();
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_hdr_ignored: locked=%b required 0", bus.locked); end
        rst         = 1'b0;
        bus.inValid = 1'b0;
        #1;
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL reset_release_inReady: got %b required 1", bus.inReady); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        send_word(32'hBC35_0000);
        n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL basic_lock: locked=%b required 1", bus.locked); end
        send_word(32'h0102_FF80);
        n_checks++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h0008_0010) begin n_fail++; $display("FAIL basic_s0: valid=%b data=%h required 1/00080010", bus.outValid, bus.outData); end
        n_checks++; if (bus.outFirst !== 1'b1) begin n_fail++; $display("FAIL basic_first: got %b required 1", bus.outFirst); end
        n_checks++; if (bus.outScalingFactor !== 4'd3 || bus.outControlData !== 4'd5) begin n_fail++; $display("FAIL basic_fields: factor=%0d control=%0d required 3/5", bus.outScalingFactor, bus.outControlData); end
        tick();
        n_checks++; if (bus.outData !== 32'hFFF8_FC00 || bus.outFirst !== 1'b0) begin n_fail++; $display("FAIL basic_s1: data=%h first=%b required fff8fc00/0", bus.outData, bus.outFirst); end
        for (int k = 1; k < 8; k++) send_word(32'h0000_0000);
        send_word(32'hBC53_0000);
        n_checks++; if (bus.locked !== 1'b1 || bus.syncErrCount !== 8'd0) begin n_fail++; $display("FAIL basic_relock: locked=%b err=%0d required 1/0", bus.locked, bus.syncErrCount); end
        send_word(32'h0102_FF80);
        n_checks++; if (bus.outData !== 32'h0020_0040 || bus.outFirst !== 1'b1) begin n_fail++; $display("FAIL frame2_s0: data=%h first=%b required 00200040/1", bus.outData, bus.outFirst); end
        n_checks++; if (bus.outScalingFactor !== 4'd5 || bus.outControlData !== 4'd3) begin n_fail++; $display("FAIL frame2_fields: factor=%0d control=%0d required 5/3", bus.outScalingFactor, bus.outControlData); end
        tick();
        n_checks++; if (bus.outData !== 32'hFFE0_F000) begin n_fail++; $display("FAIL frame2_s1: data=%h required ffe0f000", bus.outData); end
    endtask

    task automatic test_saturation();
        do_reset();
        send_word(32'hBC90_0000);
        send_word(32'h7F80_0000);
        n_checks++; if (bus.outData !== 32'h7FFF_8000 || bus.outScalingFactor !== 4'd9) begin n_fail++; $display("FAIL sat_s0: data=%h factor=%0d required 7fff8000/9", bus.outData, bus.outScalingFactor); end
        tick();
        n_checks++; if (bus.outData !== 32'h0000_0000) begin n_fail++; $display("FAIL sat_s1: data=%h required 00000000", bus.outData); end
        send_word(32'h01FF_4000);
        n_checks++; if (bus.outData !== 32'h0200_FE00 || bus.outFirst !== 1'b0) begin n_fail++; $display("FAIL sat_w1_s0: data=%h first=%b required 0200fe00/0", bus.outData, bus.outFirst); end
        tick();
        n_checks++; if (bus.outData !== 32'h7FFF_0000) begin n_fail++; $display("FAIL sat_w1_s1: data=%h required 7fff0000", bus.outData); end
    endtask

    task automatic test_sync_loss();
        do_reset();
        send_word(32'hBC12_0000);
        for (int k = 0; k < 8; k++) send_word(32'h0101_0101);
        send_word(32'h1234_5678);
        n_checks++; if (bus.locked !== 1'b0 || bus.syncErrCount !== 8'd1) begin n_fail++; $display("FAIL sync_loss: locked=%b err=%0d required 0/1", bus.locked, bus.syncErrCount); end
        repeat (4) tick();
        mon_q.delete();
        for (int k = 0; k < 3; k++) send_word(32'h1111_1111);
        repeat (4) tick();
        n_checks++; if (mon_q.size() != 0 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL hunt_discard: samples=%0d locked=%b required 0/0", mon_q.size(), bus.locked); end
        send_word(32'hBC00_0000);
        n_checks++; if (bus.locked !== 1'b1 || bus.syncErrCount !== 8'd1) begin n_fail++; $display("FAIL resync: locked=%b err=%0d required 1/1", bus.locked, bus.syncErrCount); end
        send_word(32'h0101_0101);
        n_checks++; if (bus.outData !== 32'h0001_0001 || bus.outFirst !== 1'b1) begin n_fail++; $display("FAIL resync_s0: data=%h first=%b required 00010001/1", bus.outData, bus.outFirst); end
    endtask

    task automatic test_bad_header();
        do_reset();
        mon_q.delete();
        send_word(32'hBC35_0001);
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL bad_hdr_lock: locked=%b required 0", bus.locked); end
        send_word(32'h0102_0304);
        repeat (3) tick();
        n_checks++; if (mon_q.size() != 0 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL bad_hdr_output: samples=%0d locked=%b required 0/0", mon_q.size(), bus.locked); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [40:0] exp_e;
        logic [7:0]  b0, b1, b2, b3;
        int          waited;
        do_reset();
        mon_q.delete();
        send_word(32'hBC00_0000);
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send_word({8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
                end
            end
            begin
                repeat (4) tick();
                bus.outReady = 1'b0;
                held = bus.outData;
                n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_at_stall: got %b required 1", bus.outValid); end
                for (int c = 0; c < 5; c++) begin
                    tick();
                    n_checks++; if (bus.outValid !== 1'b1 || bus.outData !== held) begin n_fail++; $display("FAIL bp_stable cycle %0d: valid=%b data=%h required 1/%h", c, bus.outValid, bus.outData, held); end
                end
                n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL bp_inReady: got %b required 0", bus.inReady); end
                bus.outReady = 1'b1;
            end
        join
        waited = 0;
        while (mon_q.size() < 16 && waited < 40) begin tick(); waited++; end
        repeat (3) tick();
        n_checks++; if (mon_q.size() != 16) begin n_fail++; $display("FAIL bp_count: samples=%0d required 16", mon_q.size()); end
        for (int i = 0; i < 16 && i < mon_q.size(); i++) begin
            b0 = 8'(2*i+1);
            b1 = 8'(2*i+2);
            exp_e = {(i == 0), 4'd0, 4'd0, 8'h00, b0, 8'h00, b1};
            n_checks++; if (mon_q[i] !== exp_e) begin n_fail++; $display("FAIL bp_sample %0d: got %h required %h", i, mon_q[i], exp_e); end
        end
        b2 = 8'h0; b3 = 8'h0;
        if (b2 !== b3) $display("unreachable");
    endtask

    task automatic test_reset_midframe();
        int n_seen;
        do_reset();
        send_word(32'hBC00_0000);
        send_word(32'h0A0B_0C0D);
        send_word(32'h1A1B_1C1D);
        send_word(32'h2A2B_2C2D);
        bus.outReady = 1'b0;
        tick();
        n_seen = mon_q.size();
        rst = 1'b1;
        tick();
        n_checks++; if (bus.outValid !== 1'b0 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL midrst_state: valid=%b locked=%b required 0/0", bus.outValid, bus.locked); end
        n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL midrst_inReady: got %b required 0", bus.inReady); end
        rst          = 1'b0;
        bus.outReady = 1'b1;
        #1;
        n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL midrst_release: inReady=%b required 1", bus.inReady); end
        repeat (3) tick();
        n_checks++; if (mon_q.size() != n_seen || bus.outValid !== 1'b0) begin n_fail++; $display("FAIL midrst_dropped: samples=%0d valid=%b required %0d/0", mon_q.size(), bus.outValid, n_seen); end
        send_word(32'hBC00_0000);
        n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL midrst_relock: locked=%b required 1", bus.locked); end
        send_word(32'h0300_0400);
        n_checks++; if (bus.outData !== 32'h0003_0000 || bus.outFirst !== 1'b1) begin n_fail++; $display("FAIL midrst_s0: data=%h first=%b required 00030000/1", bus.outData, bus.outFirst); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.outReady = 1'b1;
        test_reset();
        test_basic_frame();
        test_saturation();
        test_sync_loss();
        test_bad_header();
        test_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
